// File: rtl/ram_port_arbiter.sv
// Two-requester round-robin arbiter for RAM port A with a bounded lock for
// atomic read-modify-write sequences. Grants are combinational; read valids are registered.
module ram_port_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10,
    parameter int MAX_LOCK   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  r0_req,
    input  logic                  r1_req,
    input  logic                  r0_we,
    input  logic                  r1_we,
    input  logic [ADDR_WIDTH-1:0] r0_addr,
    input  logic [ADDR_WIDTH-1:0] r1_addr,
    input  logic [DATA_WIDTH-1:0] r0_wdata,
    input  logic [DATA_WIDTH-1:0] r1_wdata,
    input  logic                  r0_lock,
    input  logic                  r1_lock,
    output logic                  r0_gnt,
    output logic                  r1_gnt,
    output logic                  r0_rvalid,
    output logic                  r1_rvalid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_q
);

    localparam logic [7:0] MAX_CNT = 8'(MAX_LOCK);

    typedef enum logic [1:0] {
        IDLE,
        LOCK0,
        LOCK1
    } state_t;

    state_t     state, state_next;
    logic       last, last_next;
    logic [7:0] lock_cnt, lock_cnt_next;
    logic       gnt0, gnt1;
    logic       arbitrate;

    always_comb begin
        gnt0          = 1'b0;
        gnt1          = 1'b0;
        arbitrate     = 1'b0;
        state_next    = state;
        lock_cnt_next = lock_cnt;
        last_next     = last;

        case (state)
            LOCK0: begin
                if (r0_req) begin
                    gnt0          = 1'b1;
                    lock_cnt_next = lock_cnt + 8'd1;
                    state_next    = (r0_lock && (lock_cnt + 8'd1 < MAX_CNT)) ? LOCK0 : IDLE;
                end else begin
                    arbitrate = 1'b1;
                end
            end
            LOCK1: begin
                if (r1_req) begin
                    gnt1          = 1'b1;
                    lock_cnt_next = lock_cnt + 8'd1;
                    state_next    = (r1_lock && (lock_cnt + 8'd1 < MAX_CNT)) ? LOCK1 : IDLE;
                end else begin
                    arbitrate = 1'b1;
                end
            end
            default: arbitrate = 1'b1;
        endcase

        // An owner that drops req falls through to same-cycle IDLE arbitration.
        // A lock is only entered when MAX_LOCK leaves room for a second grant.
        if (arbitrate) begin
            state_next = IDLE;
            if (r0_req && (!r1_req || last)) begin
                gnt0 = 1'b1;
                if (r0_lock && (MAX_CNT > 8'd1)) begin
                    state_next    = LOCK0;
                    lock_cnt_next = 8'd1;
                end
            end else if (r1_req) begin
                gnt1 = 1'b1;
                if (r1_lock && (MAX_CNT > 8'd1)) begin
                    state_next    = LOCK1;
                    lock_cnt_next = 8'd1;
                end
            end
        end

        if (gnt0) begin
            last_next = 1'b0;
        end else if (gnt1) begin
            last_next = 1'b1;
        end

        if (reset) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            last      <= 1'b1;
            lock_cnt  <= '0;
            r0_rvalid <= 1'b0;
            r1_rvalid <= 1'b0;
        end else begin
            state     <= state_next;
            last      <= last_next;
            lock_cnt  <= lock_cnt_next;
            r0_rvalid <= gnt0 & ~r0_we;
            r1_rvalid <= gnt1 & ~r1_we;
        end
    end

    assign r0_gnt    = gnt0;
    assign r1_gnt    = gnt1;
    assign ram_addr  = gnt1 ? r1_addr : r0_addr;
    assign ram_wdata = gnt1 ? r1_wdata : r0_wdata;
    assign ram_we    = (gnt0 & r0_we) | (gnt1 & r1_we);
    assign rdata     = ram_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed plus random bench for ram_port_arbiter with a behavioural RAM and
// an arbitration/memory reference model.
module tb_ram_port_arbiter;

    localparam int DW   = 16;
    localparam int AW   = 10;
    localparam int MAXL = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          r0_req, r1_req, r0_we, r1_we, r0_lock, r1_lock;
    logic [AW-1:0] r0_addr, r1_addr;
    logic [DW-1:0] r0_wdata, r1_wdata;
    logic          r0_gnt, r1_gnt, r0_rvalid, r1_rvalid;
    logic [DW-1:0] rdata;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          ram_we;
    logic [DW-1:0] ram_q;

    ram_port_arbiter #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .MAX_LOCK   (MAXL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .r0_req    (r0_req),
        .r1_req    (r1_req),
        .r0_we     (r0_we),
        .r1_we     (r1_we),
        .r0_addr   (r0_addr),
        .r1_addr   (r1_addr),
        .r0_wdata  (r0_wdata),
        .r1_wdata  (r1_wdata),
        .r0_lock   (r0_lock),
        .r1_lock   (r1_lock),
        .r0_gnt    (r0_gnt),
        .r1_gnt    (r1_gnt),
        .r0_rvalid (r0_rvalid),
        .r1_rvalid (r1_rvalid),
        .rdata     (rdata),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
        .ram_q     (ram_q)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_val(input int a);
        return (a == 5) ? 16'hBEEF : (16'(a * 3) ^ 16'h5A00);
    endfunction

    // Behavioural synchronous RAM: one-cycle registered read, preloaded on its first edge
    logic [DW-1:0] mem [0:1023];
    logic          ram_loaded = 1'b0;
    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int i = 0; i < 1024; i++) mem[i] <= init_val(i);
            ram_loaded <= 1'b1;
        end else begin
            ram_q <= mem[ram_addr];
            if (ram_we) mem[ram_addr] <= ram_wdata;
        end
    end

    // Reference model state: owner of an active lock (-1 none), its grant run length
    int            n_checks = 0;
    int            n_fail   = 0;
    logic [DW-1:0] ref_mem [0:1023];
    int            owner  = -1;
    int            run    = 0;
    int            last_g = 1;
    logic          pv0 = 1'b0, pv1 = 1'b0;
    logic [DW-1:0] pend_data = '0;
    int            cur_g;
    logic          obs_g0, obs_g1, obs_rv0, obs_rv1;
    logic [DW-1:0] obs_rd;

    function automatic int exp_grant();
        if (reset) return -1;
        if (owner == 0 && r0_req) return 0;
        if (owner == 1 && r1_req) return 1;
        if (r0_req && r1_req) return 1 - last_g;
        if (r0_req) return 0;
        if (r1_req) return 1;
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_update();
        int            g;
        logic          we, lk;
        logic [AW-1:0] a;
        g = exp_grant();
        if (reset) begin
            owner = -1; run = 0; last_g = 1; pv0 = 1'b0; pv1 = 1'b0;
        end else begin
            pv0 = (g == 0) && !r0_we;
            pv1 = (g == 1) && !r1_we;
            if (g >= 0) begin
                we = (g == 1) ? r1_we   : r0_we;
                lk = (g == 1) ? r1_lock : r0_lock;
                a  = (g == 1) ? r1_addr : r0_addr;
                if (we) ref_mem[a] = (g == 1) ? r1_wdata : r0_wdata;
                else    pend_data  = ref_mem[a];
                last_g = g;
                if (g == owner) begin
                    run++;
                    if (!lk || run >= MAXL) owner = -1;
                end else begin
                    run   = 1;
                    owner = (lk && MAXL > 1) ? g : -1;
                end
            end else begin
                owner = -1;
            end
        end
    endtask

    // One clock: check outputs at the falling edge, then advance the model at the rising edge
    task automatic cycle();
        @(negedge clk);
        cur_g   = exp_grant();
        obs_g0  = r0_gnt;
        obs_g1  = r1_gnt;
        obs_rv0 = r0_rvalid;
        obs_rv1 = r1_rvalid;
        obs_rd  = rdata;
        chk("r0_gnt", r0_gnt, cur_g == 0);
        chk("r1_gnt", r1_gnt, cur_g == 1);
        chk("ram_we", ram_we, (cur_g == 0) ? r0_we : (cur_g == 1) ? r1_we : 1'b0);
        if (cur_g >= 0) begin
            chk("ram_addr", ram_addr, (cur_g == 1) ? r1_addr : r0_addr);
            if (ram_we) chk("ram_wdata", ram_wdata, (cur_g == 1) ? r1_wdata : r0_wdata);
        end
        chk("r0_rvalid", r0_rvalid, pv0);
        chk("r1_rvalid", r1_rvalid, pv1);
        if (pv0 || pv1) chk("rdata", rdata, pend_data);
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic drive0(input logic req, input logic we, input logic lk,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
        r0_req = req; r0_we = we; r0_lock = lk; r0_addr = a; r0_wdata = d;
    endtask

    task automatic drive1(input logic req, input logic we, input logic lk,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
        r1_req = req; r1_we = we; r1_lock = lk; r1_addr = a; r1_wdata = d;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(i);

        // Reset held with both requesters writing
        reset = 1'b1;
        drive0(1'b1, 1'b1, 1'b0, 10'h3FF, 16'hAAAA);
        drive1(1'b1, 1'b1, 1'b0, 10'h3FE, 16'h5555);
        repeat (3) begin
            cycle();
            chk("reset_no_gnt", {obs_g0, obs_g1}, 2'b00);
        end
        reset = 1'b0;
        cycle();
        chk("first_after_reset_r0", obs_g0, 1'b1);

        // Single read of the preloaded word
        drive0(1'b1, 1'b0, 1'b0, 10'h005, '0);
        drive1(1'b0, 1'b0, 1'b0, '0, '0);
        cycle();
        chk("single_read_gnt", obs_g0, 1'b1);
        drive0(1'b0, 1'b0, 1'b0, '0, '0);
        cycle();
        chk("single_read_rvalid0", obs_rv0, 1'b1);
        chk("single_read_rvalid1", obs_rv1, 1'b0);
        chk("single_read_data", obs_rd, 16'hBEEF);

        // r1 alone so that r0 wins the next contention
        drive1(1'b1, 1'b0, 1'b0, 10'h007, '0);
        cycle();

        // Round-robin under continuous contention
        for (int i = 0; i < 6; i++) begin
            drive0(1'b1, 1'b0, 1'b0, 10'(16 + i), '0);
            drive1(1'b1, 1'b0, 1'b0, 10'(32 + i), '0);
            cycle();
            chk("rr_gnt0", obs_g0, (i % 2) == 0);
            chk("rr_gnt1", obs_g1, (i % 2) == 1);
            if (i > 0) chk("rr_rvalid0_follows", obs_rv0, ((i - 1) % 2) == 0);
        end

        // Cross-bank write then reads of both banks
        drive0(1'b0, 1'b0, 1'b0, '0, '0);
        drive1(1'b1, 1'b1, 1'b0, 10'h201, 16'h1234);
        cycle();
        drive1(1'b0, 1'b0, 1'b0, '0, '0);
        drive0(1'b1, 1'b0, 1'b0, 10'h201, '0);
        cycle();
        drive0(1'b1, 1'b0, 1'b0, 10'h001, '0);
        cycle();
        chk("xbank_high", obs_rd, 16'h1234);
        drive0(1'b0, 1'b0, 1'b0, '0, '0);
        cycle();
        chk("xbank_low", obs_rd, init_val(1));

        // Lock timeout: r0 keeps MAX_LOCK grants, then r1 wins
        drive1(1'b1, 1'b0, 1'b0, 10'h008, '0);
        cycle();
        drive0(1'b1, 1'b0, 1'b1, 10'h030, '0);
        drive1(1'b1, 1'b0, 1'b0, 10'h040, '0);
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("lock_timeout_gnt0", obs_g0, i < MAXL);
            chk("lock_timeout_gnt1", obs_g1, i == MAXL);
        end

        // Lock release: owner drops req, other requester granted the same cycle
        drive0(1'b1, 1'b0, 1'b1, 10'h050, '0);
        drive1(1'b0, 1'b0, 1'b0, '0, '0);
        cycle();
        drive0(1'b0, 1'b0, 1'b0, '0, '0);
        drive1(1'b1, 1'b0, 1'b0, 10'h060, '0);
        cycle();
        chk("lock_release_gnt1", obs_g1, 1'b1);
        chk("lock_release_gnt0", obs_g0, 1'b0);

        // Reset during an r1 lock
        drive1(1'b1, 1'b0, 1'b1, 10'h070, '0);
        cycle();
        chk("r1_lock_gnt", obs_g1, 1'b1);
        reset = 1'b1;
        drive0(1'b1, 1'b0, 1'b0, 10'h080, '0);
        repeat (2) begin
            cycle();
            chk("midlock_reset_no_gnt", {obs_g0, obs_g1}, 2'b00);
        end
        reset = 1'b0;
        cycle();
        chk("post_reset_r0_wins", obs_g0, 1'b1);

        // Random traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 49) == 0);
            drive0($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
                   $urandom_range(0, 2) == 0, 10'($urandom_range(0, 1023)), 16'($urandom));
            drive1($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
                   $urandom_range(0, 2) == 0, 10'($urandom_range(0, 1023)), 16'($urandom));
            cycle();
        end
        reset = 1'b0;
        drive0(1'b0, 1'b0, 1'b0, '0, '0);
        drive1(1'b0, 1'b0, 1'b0, '0, '0);
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
